// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle signed/unsigned multiply and divide with private
// HI/LO registers, driven over a start/busy/done handshake.
// Multiply is shift-add (LSB first), divide is restoring (MSB first). Both
// work on unsigned magnitudes, and the recorded signs are applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] oper_A,
  input  logic [WIDTH-1:0] oper_B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  // Multiply: opnd = multiplicand magnitude, shreg = multiplier shifting out
  // LSB first while product low bits shift in from the top.
  // Divide: opnd = divisor magnitude, shreg = dividend shifting out MSB
  // first while quotient bits shift in from the bottom.
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH:0]   acc;
  logic             neg_q;
  logic             neg_r;
  logic             is_div;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes, one iteration step of each algorithm, and sign fixup
  always_comb begin
    a_neg     = (op == OP_MULT || op == OP_DIV) && oper_A[WIDTH-1];
    b_neg     = (op == OP_MULT || op == OP_DIV) && oper_B[WIDTH-1];
    a_mag     = a_neg ? (-oper_A) : oper_A;
    b_mag     = b_neg ? (-oper_B) : oper_B;
    mul_sum   = acc + (shreg[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, shreg[WIDTH-1]};
    div_diff  = div_shift - {2'b00, opnd};
    prod      = {acc[WIDTH-1:0], shreg};
    prod_fix  = neg_q ? (-prod) : prod;
    quo_fix   = neg_q ? (-shreg) : shreg;
    rem_fix   = neg_r ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      opnd     <= '0;
      shreg    <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                opnd     <= a_mag;
                shreg    <= b_mag;
                acc      <= '0;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= 1'b0;
                is_div   <= 1'b0;
                cnt      <= '0;
                busy     <= 1'b1;
                div_zero <= 1'b0;
                state    <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                if (oper_B == '0) begin
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                end else begin
                  opnd     <= b_mag;
                  shreg    <= a_mag;
                  acc      <= '0;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  is_div   <= 1'b1;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  div_zero <= 1'b0;
                  state    <= DIV;
                end
              end
              OP_MTHI: begin
                hi       <= oper_A;
                done     <= 1'b1;
                div_zero <= 1'b0;
              end
              OP_MTLO: begin
                lo       <= oper_A;
                done     <= 1'b1;
                div_zero <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          // acc never exceeds WIDTH bits here, so its top bit is always 0
          acc   <= {1'b0, mul_sum[WIDTH:1]};
          shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        DIV: begin
          if (!div_diff[WIDTH+1]) begin
            acc   <= div_diff[WIDTH:0];
            shreg <= {shreg[WIDTH-2:0], 1'b1};
          end else begin
            acc   <= div_shift[WIDTH:0];
            shreg <= {shreg[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/div_zero
// and busy-cycle counts; per-instance monitors pop on every done pulse.
module tb_muldiv_unit;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                         DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        busy32, done32, dz32;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dz8;

  muldiv_unit #(.WIDTH(32)) u32 (
    .Clk(clk), .reset(reset), .start(start32), .op(op32),
    .oper_A(a32), .oper_B(b32), .busy(busy32), .done(done32),
    .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .Clk(clk), .reset(reset), .start(start8), .op(op8),
    .oper_A(a8), .oper_B(b8), .busy(busy8), .done(done8),
    .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned bcyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int unsigned bc32 = 0, bc8 = 0;
  int n_total = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    if (!reset) bc32 = 0;
    else begin
      if (busy32) bc32++;
      if (done32) begin
        if (q32.size() == 0) begin
          n_total++;
          $display("FAIL stray_done32: done=1 with nothing outstanding");
        end else begin
          e32 = q32.pop_front();
          chk({e32.name, "_hi"}, hi32, e32.hi);
          chk({e32.name, "_lo"}, lo32, e32.lo);
          chk({e32.name, "_dz"}, {31'b0, dz32}, {31'b0, e32.dz});
          chk({e32.name, "_busy_cycles"}, bc32, e32.bcyc);
          chk({e32.name, "_busy_at_done"}, {31'b0, busy32}, 32'h0);
        end
        bc32 = 0;
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (!reset) bc8 = 0;
    else begin
      if (busy8) bc8++;
      if (done8) begin
        if (q8.size() == 0) begin
          n_total++;
          $display("FAIL stray_done8: done=1 with nothing outstanding");
        end else begin
          e8 = q8.pop_front();
          chk({e8.name, "_hi"}, {24'b0, hi8}, e8.hi);
          chk({e8.name, "_lo"}, {24'b0, lo8}, e8.lo);
          chk({e8.name, "_dz"}, {31'b0, dz8}, {31'b0, e8.dz});
          chk({e8.name, "_busy_cycles"}, bc8, e8.bcyc);
        end
        bc8 = 0;
      end
    end
  end

  task automatic push32(input string n, input logic [31:0] h, input logic [31:0] l,
                        input logic dz, input int unsigned bc);
    exp_t e;
    e.name = n; e.hi = h; e.lo = l; e.dz = dz; e.bcyc = bc;
    q32.push_back(e);
  endtask

  task automatic push8(input string n, input logic [31:0] h, input logic [31:0] l,
                       input logic dz, input int unsigned bc);
    exp_t e;
    e.name = n; e.hi = h; e.lo = l; e.dz = dz; e.bcyc = bc;
    q8.push_back(e);
  endtask

  task automatic issue32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = a; b32 = b;
    @(negedge clk);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic drain32();
    for (int i = 0; i < 200 && q32.size() != 0; i++) @(negedge clk);
    if (q32.size() != 0) begin
      n_total++;
      $display("FAIL timeout32: %0d results outstanding, required 0", q32.size());
      q32.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain8();
    for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      n_total++;
      $display("FAIL timeout8: %0d results outstanding, required 0", q8.size());
      q8.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy32}, 32'h0);
    chk("rst_done", {31'b0, done32}, 32'h0);
    chk("rst_dz", {31'b0, dz32}, 32'h0);
    chk("rst_hi", hi32, 32'h0);
    chk("rst_lo", lo32, 32'h0);
    chk("rst8_hilo", {16'b0, hi8, lo8}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Signed / unsigned multiply
    push32("mult_m3x5", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
    issue32(MULT, 32'hFFFFFFFD, 32'd5);
    drain32();
    push32("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    issue32(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drain32();
    push32("mult_m1m1", 32'h0, 32'h1, 1'b0, 33);
    issue32(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drain32();

    // Divide, including MIN / -1
    push32("div_m7d2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    issue32(DIV, 32'hFFFFFFF9, 32'd2);
    drain32();
    push32("divu_7d2", 32'h1, 32'h3, 1'b0, 33);
    issue32(DIVU, 32'd7, 32'd2);
    drain32();
    push32("div_min_m1", 32'h0, 32'h80000000, 1'b0, 33);
    issue32(DIV, 32'h80000000, 32'hFFFFFFFF);
    drain32();

    // MTHI/MTLO and divide by zero
    push32("mthi", 32'h11, 32'h80000000, 1'b0, 0);
    issue32(MTHI, 32'h11, 32'h0);
    drain32();
    push32("mtlo", 32'h11, 32'h22, 1'b0, 0);
    issue32(MTLO, 32'h22, 32'h0);
    drain32();
    push32("divu_by0", 32'h11, 32'h22, 1'b1, 0);
    issue32(DIVU, 32'd7, 32'd0);
    drain32();
    push32("mtlo_after_dz", 32'h11, 32'h5, 1'b0, 0);
    issue32(MTLO, 32'h5, 32'h0);
    drain32();

    // Start during busy must be ignored
    push32("multu_ign", 32'h1, 32'h23456780, 1'b0, 33);
    issue32(MULTU, 32'h12345678, 32'h10);
    repeat (5) @(negedge clk);
    start32 = 1'b1; op32 = MTHI; a32 = 32'hDEADBEEF;
    @(negedge clk);
    start32 = 1'b0;
    drain32();

    // Reserved op: no done (monitor flags any), nothing changes
    issue32(3'b110, 32'hCAFEF00D, 32'h1);
    repeat (6) @(negedge clk);
    chk("rsvd_hi", hi32, 32'h1);
    chk("rsvd_lo", lo32, 32'h23456780);
    chk("rsvd_busy", {31'b0, busy32}, 32'h0);

    // Reset aborting a MULT at iteration 10
    issue32(MULT, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'b0, busy32}, 32'h0);
    chk("abort_done", {31'b0, done32}, 32'h0);
    chk("abort_dz", {31'b0, dz32}, 32'h0);
    chk("abort_hi", hi32, 32'h0);
    chk("abort_lo", lo32, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (45) @(negedge clk);

    // WIDTH=8: MULT then back-to-back DIV accepted in the done cycle
    push8("w8_mult_80x80", 32'h40, 32'h00, 1'b0, 9);
    push8("w8_div_81d2", 32'hFF, 32'hC1, 1'b0, 9);
    issue8(MULT, 8'h80, 8'h80);
    for (int i = 0; i < 40 && !done8; i++) @(negedge clk);
    if (!done8) begin
      n_total++;
      $display("FAIL w8_done_wait: done never seen, required 1");
    end
    start8 = 1'b1; op8 = DIV; a8 = 8'h81; b8 = 8'h02;
    @(negedge clk);
    start8 = 1'b0;
    drain8();
    push8("w8_divu_ffd10", 32'h0F, 32'h0F, 1'b0, 9);
    issue8(DIVU, 8'hFF, 8'h10);
    drain8();
    push8("w8_div_min_m1", 32'h00, 32'h80, 1'b0, 9);
    issue8(DIV, 8'h80, 8'hFF);
    drain8();
    push8("w8_multu_ffxff", 32'hFE, 32'h01, 1'b0, 9);
    issue8(MULTU, 8'hFF, 8'hFF);
    drain8();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
